traffic_sequencer: RTL and testbench

Timing controller that drives the `change` input of the traffic_lights FSM and watches its `redout`/`yellowout`/`greenout` outputs.
- Counts a programmable dwell per colour and issues a one-cycle `change` pulse when the dwell expires.
- Confirms that the lights advance, cuts green short on a latched pedestrian request, and raises a sticky fault on protocol violations.

---
 rtl/traffic_sequencer.sv | 155 +++++++++++++++
 tb/tb_traffic_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_sequencer.sv
// Dwell timer and protocol watchdog driving the change input of traffic_lights.
// Issues one-cycle advance pulses, shortens green on pedestrian demand, latches faults.
module traffic_sequencer #(
  parameter int unsigned RED_TICKS    = 8,
  parameter int unsigned GREEN_TICKS  = 12,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned MIN_GREEN    = 5,
  parameter int unsigned ACK_TIMEOUT  = 3
) (
  input  logic clock,
  input  logic resetL,
  input  logic redout,
  input  logic yellowout,
  input  logic greenout,
  input  logic ped_req,
  output logic change,
  output logic ped_walk,
  output logic fault
);

  localparam logic [1:0] S_TIMING  = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_FAULT   = 2'd2;

  localparam logic [1:0] C_R = 2'd0;
  localparam logic [1:0] C_G = 2'd1;
  localparam logic [1:0] C_Y = 2'd2;
  localparam logic [1:0] C_X = 2'd3;

  localparam logic [7:0] RED_LAST = 8'(RED_TICKS - 1);
  localparam logic [7:0] GRN_LAST = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] YEL_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] MIN_LAST = 8'(MIN_GREEN - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  logic [1:0] state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] tcnt, tcnt_n;
  logic [1:0] col, col_n;
  logic       have_col, have_col_n;
  logic       pend, pend_n;
  logic       change_n, walk_n, fault_n, go_fault;
  logic [1:0] cur;

  function automatic logic [1:0] next_col(input logic [1:0] c);
    case (c)
      C_R:     next_col = C_G;
      C_G:     next_col = C_Y;
      default: next_col = C_R;
    endcase
  endfunction

  // True when dwell index n of colour c must carry the change pulse.
  function automatic logic pulse_due(input logic [1:0] c, input logic [7:0] n, input logic p);
    case (c)
      C_R:     pulse_due = (n == RED_LAST);
      C_Y:     pulse_due = (n == YEL_LAST);
      C_G:     pulse_due = (n == GRN_LAST) || (p && (n >= MIN_LAST));
      default: pulse_due = 1'b0;
    endcase
  endfunction

  always_comb begin
    case ({redout, yellowout, greenout})
      3'b100:  cur = C_R;
      3'b010:  cur = C_Y;
      3'b001:  cur = C_G;
      default: cur = C_X;
    endcase
  end

  // cnt is the dwell index of the current cycle; the confirming cycle is index 0,
  // so the first TIMING cycle after it is index 1. change is precomputed one edge early.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    col_n      = col;
    have_col_n = have_col;
    pend_n     = pend | ped_req;
    walk_n     = ped_walk;
    change_n   = 1'b0;
    go_fault   = 1'b0;
    case (state)
      S_TIMING: begin
        if (cur == C_X || (have_col && cur != col)) begin
          go_fault = 1'b1;
        end else if (change) begin
          state_n = S_CONFIRM;
          tcnt_n  = '0;
          if (col == C_Y && pend) begin
            walk_n = 1'b1;
            pend_n = ped_req;
          end
          if (col == C_R) walk_n = 1'b0;
        end else begin
          cnt_n      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          col_n      = cur;
          have_col_n = 1'b1;
          change_n   = pulse_due(cur, cnt_n, pend_n);
        end
      end
      S_CONFIRM: begin
        if (cur == C_X) begin
          go_fault = 1'b1;
        end else if (cur == next_col(col)) begin
          state_n  = S_TIMING;
          cnt_n    = 8'd1;
          col_n    = cur;
          change_n = pulse_due(cur, 8'd1, pend_n);
        end else if (cur == col) begin
          if (tcnt == ACK_LAST) go_fault = 1'b1;
          else                  tcnt_n = tcnt + 4'd1;
        end else begin
          go_fault = 1'b1;
        end
      end
      default: begin
        pend_n = pend;
        walk_n = 1'b0;
      end
    endcase
    if (go_fault) begin
      state_n  = S_FAULT;
      change_n = 1'b0;
      walk_n   = 1'b0;
    end
    fault_n = (state_n == S_FAULT);
  end

  always_ff @(posedge clock or negedge resetL) begin
    if (!resetL) begin
      state    <= S_TIMING;
      cnt      <= '0;
      tcnt     <= '0;
      col      <= C_R;
      have_col <= 1'b0;
      pend     <= 1'b0;
      change   <= 1'b0;
      ped_walk <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tcnt     <= tcnt_n;
      col      <= col_n;
      have_col <= have_col_n;
      pend     <= pend_n;
      change   <= change_n;
      ped_walk <= walk_n;
      fault    <= fault_n;
    end
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: behavioural traffic_lights model, table-driven
// full-cycle scenarios, and hand-written fault and reset sequences.
module tb_traffic_sequencer;

  logic clock = 1'b0;
  logic resetL = 1'b0;
  logic redout = 1'b1;
  logic yellowout = 1'b0;
  logic greenout = 1'b0;
  logic ped_req = 1'b0;
  logic change, ped_walk, fault;

  int unsigned tests = 0;
  int unsigned failed = 0;
  bit lights_auto = 1'b1;

  traffic_sequencer #(
    .RED_TICKS(8), .GREEN_TICKS(12), .YELLOW_TICKS(4), .MIN_GREEN(5), .ACK_TIMEOUT(3)
  ) dut (
    .clock(clock), .resetL(resetL), .redout(redout), .yellowout(yellowout),
    .greenout(greenout), .ped_req(ped_req), .change(change), .ped_walk(ped_walk),
    .fault(fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned     ped_cycle;
    logic [5:0][7:0] pulses;
    int unsigned     walk_lo;
    int unsigned     walk_hi;
    int unsigned     ncyc;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One clock: the lights model follows change as seen in the cycle just ending.
  task automatic tick();
    logic c;
    c = change;
    @(posedge clock);
    #1;
    if (lights_auto && c) begin
      if (redout)       {redout, yellowout, greenout} = 3'b001;
      else if (greenout) {redout, yellowout, greenout} = 3'b010;
      else              {redout, yellowout, greenout} = 3'b100;
    end
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge of cycle 0 (resetL just released, lamps red).
  task automatic do_reset();
    @(negedge clock);
    resetL = 1'b0;
    ped_req = 1'b0;
    lights_auto = 1'b1;
    {redout, yellowout, greenout} = 3'b100;
    #1;
    check("reset change", change, 1'b0);
    check("reset ped_walk", ped_walk, 1'b0);
    check("reset fault", fault, 1'b0);
    @(negedge clock);
    @(negedge clock);
    resetL = 1'b1;
  endtask

  initial begin
    logic exp_c, exp_w;

    // ped_cycle, pulse cycles (FF unused), walk window, cycles to run
    vecs[0] = '{999, {8'd47, 8'd43, 8'd31, 8'd23, 8'd19, 8'd7}, 999, 0, 50};
    vecs[1] = '{9,   {8'd40, 8'd36, 8'd24, 8'd16, 8'd12, 8'd7}, 17, 24, 45};
    vecs[2] = '{17,  {8'hFF, 8'd42, 8'd30, 8'd22, 8'd18, 8'd7}, 23, 30, 45};

    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int unsigned n = 0; n < vecs[v].ncyc; n++) begin
        exp_c = 1'b0;
        for (int i = 0; i < 6; i++)
          if (n == {24'd0, vecs[v].pulses[i]}) exp_c = 1'b1;
        exp_w = (n >= vecs[v].walk_lo) && (n <= vecs[v].walk_hi);
        check($sformatf("v%0d change@%0d", v, n), change, exp_c);
        check($sformatf("v%0d ped_walk@%0d", v, n), ped_walk, exp_w);
        check($sformatf("v%0d fault@%0d", v, n), fault, 1'b0);
        ped_req = (n == vecs[v].ped_cycle);
        tick();
      end
      ped_req = 1'b0;
    end

    // Lamps stuck red after the red pulse: timeout on the third CONFIRM edge.
    do_reset();
    lights_auto = 1'b0;
    for (int unsigned n = 0; n < 22; n++) begin
      check($sformatf("stuck change@%0d", n), change, n == 7);
      check($sformatf("stuck fault@%0d", n), fault, n >= 11);
      tick();
    end
    do_reset();
    for (int unsigned n = 0; n < 10; n++) begin
      check($sformatf("after stuck change@%0d", n), change, n == 7);
      check($sformatf("after stuck fault@%0d", n), fault, 1'b0);
      tick();
    end

    // Red and green together for one green cycle.
    do_reset();
    for (int unsigned n = 0; n < 30; n++) begin
      check($sformatf("illegal change@%0d", n), change, n == 7);
      check($sformatf("illegal fault@%0d", n), fault, n >= 13);
      check($sformatf("illegal ped_walk@%0d", n), ped_walk, 1'b0);
      if (n == 12) redout = 1'b1;
      if (n == 20) ped_req = 1'b1;
      tick();
      if (n == 12) redout = 1'b0;
    end
    ped_req = 1'b0;

    // Reset asserted in the middle of the change pulse.
    do_reset();
    for (int unsigned n = 0; n < 7; n++) tick();
    check("pulse before reset", change, 1'b1);
    resetL = 1'b0;
    #1;
    check("change cleared by async reset", change, 1'b0);
    @(negedge clock);
    @(negedge clock);
    {redout, yellowout, greenout} = 3'b100;
    resetL = 1'b1;
    for (int unsigned n = 0; n < 10; n++) begin
      check($sformatf("restart change@%0d", n), change, n == 7);
      check($sformatf("restart fault@%0d", n), fault, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
